dmem_arbiter: RTL
=================

Name: dmem_arbiter

Overview:
- Two-port arbiter and sequencer that shares the single-ported data_mem between the CPU MEM stage and a debug/loader port.
- Grants one access per cycle and drives data_mem r/w/addr/data_in.
- Tracks the one-cycle registered read latency of data_mem and returns read data with a valid strobe to the owning requester.
- Generates the MEM-stage stall when the CPU loses arbitration.

Parameters:
- FAIR_MODE, 1, 1 = round-robin between cpu and dbg; 0 = cpu fixed priority with starvation guard.
- DBG_MAX_WAIT, 4, FAIR_MODE=0 only: cycles dbg_req may be refused before dbg is forcibly granted; range 1..15.

Ports:
- clk  input  1  system clock, all state updates on posedge.
- rst  input  1  asynchronous, active-high reset.
- cpu_req  input  1  CPU access request.
- cpu_we  input  1  1 = write, 0 = read.
- cpu_addr  input  32  word address.
- cpu_wdata  input  32  write data.
- cpu_gnt  output  1  access accepted this cycle (combinational).
- cpu_stall  output  1  cpu_req & ~cpu_gnt.
- cpu_rvalid  output  1  cpu_rdata valid this cycle.
- cpu_rdata  output  32  read data.
- dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_gnt, dbg_rvalid, dbg_rdata: same widths and meanings for the debug/loader requester.
- mem_r  output  1  to data_mem r.
- mem_w  output  1  to data_mem w.
- mem_addr  output  32  to data_mem addr.
- mem_wdata  output  32  to data_mem data_in.
- mem_rdata  input  32  from data_mem data_out.

Behaviour:
- Handshake:
  - Requester holds req/we/addr/wdata stable until it sees gnt high in the same cycle.
  - The access completes at the posedge ending that cycle.
  - Requester may drop req only after gnt.
- Grant is combinational from the current req inputs and the registered state.
- At most one of cpu_gnt/dbg_gnt is high in any cycle.
- No grant while rst is high.
- Mem drive:
  - Winner's addr/wdata are muxed to mem_addr/mem_wdata.
  - mem_w = gnt & we; mem_r = gnt & ~we.
  - mem_r and mem_w are never both high.
  - With no grant: mem_r = mem_w = 0; mem_addr/mem_wdata hold the cpu values.
- Round-robin (FAIR_MODE=1):
  - 1-bit last-owner register, updated on each grant.
  - On contention, the requester that did not win last wins.
  - A sole requester always wins.
- Fixed priority (FAIR_MODE=0):
  - cpu wins contention.
  - 4-bit wait counter increments each cycle dbg_req=1 & dbg_gnt=0, saturating at 15.
  - Counter clears on dbg_gnt or when dbg_req=0.
  - When counter == DBG_MAX_WAIT, dbg wins contention that cycle.
- Read-return FSM, states IDLE, RD_CPU, RD_DBG:
  - Next state = RD_CPU on a cpu read grant, RD_DBG on a dbg read grant, else IDLE.
  - This applies from any state, so back-to-back reads are allowed every cycle.
  - In RD_CPU: cpu_rvalid=1 and cpu_rdata=mem_rdata; same for dbg in RD_DBG.
  - Read latency is exactly 1 cycle after the grant cycle.
  - A write grant causes no rvalid.
- Non-owner rdata output is held at 0; rvalid is 0 outside the owner state.
- Read-then-write back-to-back is legal: rvalid of the read coincides with the write grant.
- Reset values, async on rst rising:
  - FSM = IDLE.
  - last-owner = dbg, so cpu wins the first contention.
  - Wait counter = 0.
  - All rvalid = 0; all rdata = 0; gnt/mem_r/mem_w forced 0.
- Reset mid-operation: any pending read response is dropped, with no rvalid after reset release.
- Address width: the full 32 bits pass through; data_mem uses [15:0], and the arbiter does not truncate.

Test Plan:
- d_mem[2]=31 preloaded; cpu read addr 2 alone: cpu_gnt=1 in cycle N, mem_r=1, mem_addr=2 -> cpu_rvalid=1 and cpu_rdata=31 in N+1, dbg_rvalid=0.
- FAIR_MODE=1, cpu and dbg reads held continuously, cpu addr 3, dbg addr 4, after reset: grants alternate cpu,dbg,cpu,... -> rdata 1024 to cpu and 9 to dbg on alternate cycles; cpu_stall=1 exactly on dbg-grant cycles.
- dbg write addr 5 data 77, then cpu read addr 5 next cycle: mem_w=1 only in the write cycle -> cpu_rdata=77 one cycle after its grant.
- FAIR_MODE=0, DBG_MAX_WAIT=4, cpu_req held high with reads, dbg_req high: dbg refused 4 cycles, granted in cycle 5 -> cpu_stall=1 that cycle; counter back to 0.
- Assert rst in the cycle after a cpu read grant of addr 6: cpu_rvalid=0 immediately and stays 0 after release; the next cpu read of addr 6 returns 10.
- Randomised both-port traffic, 1000 cycles: never both gnt, never mem_r&mem_w, every read grant yields exactly one rvalid on the correct port one cycle later.

Source files
------------

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-ported data_mem between the CPU MEM stage
// and a debug/loader port, and routes the one-cycle-late read data back.
module dmem_arbiter #(
    parameter int unsigned FAIR_MODE    = 1,
    parameter int unsigned DBG_MAX_WAIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic        cpu_gnt,
    output logic        cpu_stall,
    output logic        cpu_rvalid,
    output logic [31:0] cpu_rdata,
    input  logic        dbg_req,
    input  logic        dbg_we,
    input  logic [31:0] dbg_addr,
    input  logic [31:0] dbg_wdata,
    output logic        dbg_gnt,
    output logic        dbg_rvalid,
    output logic [31:0] dbg_rdata,
    output logic        mem_r,
    output logic        mem_w,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    localparam int unsigned CW      = 4;
    localparam int unsigned CNT_MAX = 15;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RD_CPU = 2'd1,
        RD_DBG = 2'd2
    } state_t;

    state_t          state;
    state_t          next_state;
    logic            last_dbg;   // 1 = dbg owned the most recent grant
    logic [CW-1:0]   wait_cnt;
    logic            dbg_wins;

    // Arbitration: decides the contention winner and issues at most one grant
    always_comb begin
        cpu_gnt  = 1'b0;
        dbg_gnt  = 1'b0;
        if (FAIR_MODE != 0) begin
            dbg_wins = ~last_dbg;
        end else begin
            dbg_wins = (wait_cnt == CW'(DBG_MAX_WAIT));
        end
        if (!rst) begin
            if (cpu_req && dbg_req) begin
                cpu_gnt = ~dbg_wins;
                dbg_gnt = dbg_wins;
            end else begin
                cpu_gnt = cpu_req;
                dbg_gnt = dbg_req;
            end
        end
    end

    assign cpu_stall = cpu_req & ~cpu_gnt;

    // Memory drive: winner's request goes out; cpu values are the idle default
    assign mem_addr  = dbg_gnt ? dbg_addr  : cpu_addr;
    assign mem_wdata = dbg_gnt ? dbg_wdata : cpu_wdata;
    assign mem_w     = (cpu_gnt & cpu_we)  | (dbg_gnt & dbg_we);
    assign mem_r     = (cpu_gnt & ~cpu_we) | (dbg_gnt & ~dbg_we);

    // Last-owner register; reset to dbg so cpu wins the first contention
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_dbg <= 1'b1;
        end else if (cpu_gnt) begin
            last_dbg <= 1'b0;
        end else if (dbg_gnt) begin
            last_dbg <= 1'b1;
        end
    end

    // Starvation counter: cycles dbg has been refused, saturating
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt <= '0;
        end else if (!dbg_req || dbg_gnt) begin
            wait_cnt <= '0;
        end else if (wait_cnt != CW'(CNT_MAX)) begin
            wait_cnt <= wait_cnt + CW'(1);
        end
    end

    // Read-return state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next state: whoever got a read grant this cycle owns the next data beat
    always_comb begin
        next_state = IDLE;
        if (cpu_gnt && !cpu_we) begin
            next_state = RD_CPU;
        end else if (dbg_gnt && !dbg_we) begin
            next_state = RD_DBG;
        end
    end

    // Read-return outputs: only the owner sees data, others are held at 0
    always_comb begin
        cpu_rvalid = 1'b0;
        cpu_rdata  = '0;
        dbg_rvalid = 1'b0;
        dbg_rdata  = '0;
        case (state)
            RD_CPU: begin
                cpu_rvalid = 1'b1;
                cpu_rdata  = mem_rdata;
            end
            RD_DBG: begin
                dbg_rvalid = 1'b1;
                dbg_rdata  = mem_rdata;
            end
            default: begin
            end
        endcase
    end

endmodule
